// File: rtl/saturn_phase_seq.sv
// saturn_phase_seq: machine-cycle / phase sequencer for the Saturn core.
// Divides i_clk into PHASES sub-cycle phases and drives one-hot, registered
// per-phase enables. Provides run / hold / single-step control, a cycle
// counter and a runtime cycle limit with a sticky halt.
//
// Optional feature macro: SATURN_PHASE_STEP_EN (single-step state and latch).
//
// Ports:
//   i_clk            core clock
//   i_reset          asynchronous, active-high reset
//   i_run            free-run request (level)
//   i_step           single-step request (1-clock pulse)
//   i_hold           stall request, sampled only at a cycle boundary
//   i_max_cycle      cycle limit, 0 = unlimited
//   o_phase          current phase index
//   o_en             one-hot phase enables, all-zero when not executing
//   o_cycles         index of the current / last executed cycle
//   o_cycle_end      high together with o_en[PHASES-1]
//   o_out_of_cycles  sticky limit-reached flag
//   o_busy           high while running or stepping
module saturn_phase_seq #(
  parameter int unsigned PHASES = 4,
  parameter int unsigned CTR_W  = 32,
  localparam int unsigned PH_W  = $clog2(PHASES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_hold,
  input  logic [CTR_W-1:0]  i_max_cycle,
  output logic [PH_W-1:0]   o_phase,
  output logic [PHASES-1:0] o_en,
  output logic [CTR_W-1:0]  o_cycles,
  output logic              o_cycle_end,
  output logic              o_out_of_cycles,
  output logic              o_busy
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
`ifdef SATURN_PHASE_STEP_EN
    ST_STEP = 2'd2,
`endif
    ST_HALT = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PHASES-1:0]   en_q, en_d;
  logic [CTR_W-1:0]    cycles_q, cycles_d;
  logic                cycle_end_q, cycle_end_d;
  logic                oor_q, oor_d;
  logic                busy_q, busy_d;
  logic                boundary;
  logic                limit_hit;

`ifdef SATURN_PHASE_STEP_EN
  logic                step_pend_q, step_pend_d;
`else
  logic                unused_step;
  assign unused_step = i_step;
`endif

  // Next-state, phase advance and enable generation
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    en_d        = '0;
    cycles_d    = cycles_q;
    oor_d       = oor_q;
`ifdef SATURN_PHASE_STEP_EN
    step_pend_d = step_pend_q;
`endif

    boundary  = (phase_q == PH_LAST);
    // Exact match only: a limit lowered below the executed count never halts
    limit_hit = (i_max_cycle != '0) && ((cycles_q + CTR_W'(1)) == i_max_cycle);

    if (state_q != ST_HALT) begin
      if (!boundary) begin
        // Mid-cycle: always finish the cycle, control inputs are ignored
        phase_d = phase_q + PH_W'(1);
        en_d    = PHASES'(1) << phase_d;
      end else if (limit_hit) begin
        state_d = ST_HALT;
        oor_d   = 1'b1;
      end else if (i_hold) begin
        // Stall at the boundary: phase parked, state unchanged
      end else if (i_run) begin
        state_d  = ST_RUN;
        phase_d  = '0;
        en_d     = PHASES'(1);
        cycles_d = cycles_q + CTR_W'(1);
`ifdef SATURN_PHASE_STEP_EN
      end else if (step_pend_q) begin
        state_d     = ST_STEP;
        phase_d     = '0;
        en_d        = PHASES'(1);
        cycles_d    = cycles_q + CTR_W'(1);
        step_pend_d = 1'b0;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end

`ifdef SATURN_PHASE_STEP_EN
    // One-deep step latch; compares against the registered flag so a pulse
    // in the same clock the pending step is consumed is dropped
    if (i_step && !i_run && !step_pend_q) begin
      step_pend_d = 1'b1;
    end
`endif

    cycle_end_d = en_d[PHASES-1];
    busy_d      = (state_d == ST_RUN);
`ifdef SATURN_PHASE_STEP_EN
    busy_d      = busy_d || (state_d == ST_STEP);
`endif
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_LAST;
      en_q        <= '0;
      cycles_q    <= '1;
      cycle_end_q <= 1'b0;
      oor_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      en_q        <= en_d;
      cycles_q    <= cycles_d;
      cycle_end_q <= cycle_end_d;
      oor_q       <= oor_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SATURN_PHASE_STEP_EN
  // Pending single-step flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= step_pend_d;
    end
  end
`endif

  assign o_phase         = phase_q;
  assign o_en            = en_q;
  assign o_cycles        = cycles_q;
  assign o_cycle_end     = cycle_end_q;
  assign o_out_of_cycles = oor_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_saturn_phase_seq.sv
// Self-checking bench for saturn_phase_seq: a cycle-level reference model
// driven by directed and random stimulus, plus a 6-phase / 8-bit instance
// checked for counter wrap.
module tb_saturn_phase_seq;

  localparam int unsigned P = 4;
`ifdef SATURN_PHASE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, hold, step;
  logic [31:0] maxc;
  logic [1:0]  phase;
  logic [3:0]  en;
  logic [31:0] cycles;
  logic        cend, oor, busy;

  logic        rst2;
  logic [2:0]  phase2;
  logic [5:0]  en2;
  logic [7:0]  cyc2;
  logic        cend2, oor2, busy2;

  saturn_phase_seq u_dut (
    .i_clk(clk), .i_reset(rst), .i_run(run), .i_step(step), .i_hold(hold),
    .i_max_cycle(maxc), .o_phase(phase), .o_en(en), .o_cycles(cycles),
    .o_cycle_end(cend), .o_out_of_cycles(oor), .o_busy(busy)
  );

  saturn_phase_seq #(.PHASES(6), .CTR_W(8)) u_dut6 (
    .i_clk(clk), .i_reset(rst2), .i_run(1'b1), .i_step(1'b0), .i_hold(1'b0),
    .i_max_cycle(8'd0), .o_phase(phase2), .o_en(en2), .o_cycles(cyc2),
    .o_cycle_end(cend2), .o_out_of_cycles(oor2), .o_busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: abstract mode, phase number and cycle count
  int          m_mode;
  int          m_phase;
  logic [31:0] m_cyc;
  bit          m_pend, m_oor, m_act;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_phase = P - 1;
    m_cyc   = 32'hFFFF_FFFF;
    m_pend  = 1'b0;
    m_oor   = 1'b0;
    m_act   = 1'b0;
  endfunction

  // One clock of the sequencer, from the written rules
  function automatic void model_edge(input logic r, input logic h, input logic s,
                                     input logic [31:0] mx);
    logic [31:0] nxt;
    bit          pend_in;
    nxt     = m_cyc + 32'd1;
    pend_in = m_pend;
    if (m_mode == M_HALT) begin
      m_act = 1'b0;
    end else if (m_phase != P - 1) begin
      m_phase = m_phase + 1;
      m_act   = 1'b1;
    end else begin
      m_act = 1'b0;
      if (mx != 32'd0 && nxt == mx) begin
        m_mode = M_HALT;
        m_oor  = 1'b1;
      end else if (h) begin
        m_act = 1'b0;
      end else if (r) begin
        m_mode = M_RUN; m_phase = 0; m_cyc = nxt; m_act = 1'b1;
      end else if (STEP_EN && m_pend) begin
        m_mode = M_STEP; m_phase = 0; m_cyc = nxt; m_act = 1'b1; m_pend = 1'b0;
      end else begin
        m_mode = M_IDLE;
      end
    end
    if (STEP_EN && s && !r && !pend_in) m_pend = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] exp_en;
    exp_en = m_act ? (4'b0001 << m_phase) : 4'b0000;
    chk({tag, ".phase"},  64'(phase),  64'(m_phase));
    chk({tag, ".en"},     64'(en),     64'(exp_en));
    chk({tag, ".cycles"}, 64'(cycles), 64'(m_cyc));
    chk({tag, ".cend"},   64'(cend),   64'(m_act && m_phase == P - 1));
    chk({tag, ".oor"},    64'(oor),    64'(m_oor));
    chk({tag, ".busy"},   64'(busy),   64'(m_mode == M_RUN || m_mode == M_STEP));
  endtask

  // Advance one clock: model sees the inputs the DUT samples, then compare
  task automatic tick(input string tag);
    model_edge(run, hold, step, maxc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int pulses;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    run = 1'b0; hold = 1'b0; step = 1'b0; maxc = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.phase",  64'(phase),  64'd3);
    chk("rst.en",     64'(en),     64'd0);
    chk("rst.cycles", 64'(cycles), 64'hFFFF_FFFF);
    chk("rst.cend",   64'(cend),   64'd0);
    chk("rst.oor",    64'(oor),    64'd0);
    chk("rst.busy",   64'(busy),   64'd0);

    // Free run, unlimited
    run = 1'b1;
    rst = 1'b0;
    tick("run");
    chk("run.first_en",  64'(en),     64'd1);
    chk("run.first_cyc", 64'(cycles), 64'd0);
    for (int i = 1; i < 40; i++) tick("run");
    chk("run.last_cyc", 64'(cycles), 64'd9);
    chk("run.last_en",  64'(en),     64'b1000);

    // Async reset during phase 2
    repeat (3) tick("pre_rst");
    chk("pre_rst.phase", 64'(phase), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.en",     64'(en),     64'd0);
    chk("arst.phase",  64'(phase),  64'd3);
    chk("arst.cycles", 64'(cycles), 64'hFFFF_FFFF);
    chk("arst.busy",   64'(busy),   64'd0);
    @(posedge clk);
    #1;
    chk("arst.hold_en", 64'(en), 64'd0);
    rst = 1'b0;
    model_reset();
    tick("restart");
    chk("restart.cyc", 64'(cycles), 64'd0);
    chk("restart.en",  64'(en),     64'd1);

    // Cycle limit of 3
    do_reset();
    maxc = 32'd3;
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      tick("limit");
      if (en != 4'd0) pulses++;
    end
    chk("limit.pulses", 64'(pulses), 64'd12);
    chk("limit.oor",    64'(oor),    64'd1);
    chk("limit.cycles", 64'(cycles), 64'd2);
    chk("limit.en",     64'(en),     64'd0);
    chk("limit.busy",   64'(busy),   64'd0);
    maxc = 32'd0;
    repeat (4) tick("halt_sticky");

    // Hold raised in phase 1 of cycle 5
    do_reset();
    repeat (22) tick("hold_pre");
    chk("hold_pre.cyc",   64'(cycles), 64'd5);
    chk("hold_pre.phase", 64'(phase),  64'd1);
    hold = 1'b1;
    repeat (7) tick("hold");
    hold = 1'b0;
    tick("hold_rel");
    chk("hold_rel.en",  64'(en),     64'd1);
    chk("hold_rel.cyc", 64'(cycles), 64'd6);
    run = 1'b0;
    repeat (6) tick("to_idle");
    chk("to_idle.busy", 64'(busy), 64'd0);

    // Single-step: two back-to-back pulses, then one mid-cycle
    pulses = 0;
    step = 1'b1;
    tick("step");
    if (en != 4'd0) pulses++;
    tick("step");
    if (en != 4'd0) pulses++;
    step = 1'b0;
    repeat (2) begin
      tick("step");
      if (en != 4'd0) pulses++;
    end
    step = 1'b1;
    tick("step");
    if (en != 4'd0) pulses++;
    step = 1'b0;
    repeat (10) begin
      tick("step");
      if (en != 4'd0) pulses++;
    end
    chk("step.pulses", 64'(pulses), STEP_EN ? 64'd8 : 64'd0);
    chk("step.busy",   64'(busy),   64'd0);

    // Random control traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      maxc = (r % 2 == 0) ? 32'd0 : 32'($urandom_range(5, 30));
      for (int i = 0; i < 160; i++) begin
        run  = ($urandom % 4) != 0;
        hold = ($urandom % 5) == 0;
        step = ($urandom % 6) == 0;
        tick("rand");
      end
    end
    run = 1'b0; hold = 1'b0; step = 1'b0;

    // 6-phase, 8-bit counter instance: one-hot over 6 and wrap without halt
    rst2 = 1'b0;
    for (int k = 1; k <= 6 * 257 + 6; k++) begin
      @(posedge clk);
      #1;
      chk("p6.phase", 64'(phase2), 64'((k - 1) % 6));
      chk("p6.en",    64'(en2),    64'(6'b000001 << ((k - 1) % 6)));
      chk("p6.cyc",   64'(cyc2),   64'(((k - 1) / 6) % 256));
    end
    chk("p6.oor",  64'(oor2),  64'd0);
    chk("p6.busy", 64'(busy2), 64'd1);
    chk("p6.cend", 64'(cend2), 64'(en2[5]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
